// File: rtl/ahb_axi_pkg.sv
// Shared encodings for the AHB-slave to AXI-master bridge.
// Holds the HTRANS codes, the AXI response and burst codes, and the bridge state type.
package ahb_axi_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        AXI_OKAY   = 2'b00,
        AXI_EXOKAY = 2'b01,
        AXI_SLVERR = 2'b10,
        AXI_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WA,
        ST_WB,
        ST_RA,
        ST_RD,
        ST_ERR1,
        ST_ERR2
    } bridge_state_e;

    localparam logic [3:0] AXI_LEN_SINGLE = 4'h0;

endpackage

// File: rtl/ahb_xfer_check.sv
// Combinational legality check of an AHB transfer: the size must be at most a word,
// and the address must be aligned to that size.
module ahb_xfer_check (
    input  logic [2:0] h_size,
    input  logic [1:0] h_addr_lo,
    output logic       illegal
);

    always_comb begin
        illegal = 1'b0;
        case (h_size)
            3'd0:    illegal = 1'b0;
            3'd1:    illegal = h_addr_lo[0];
            3'd2:    illegal = |h_addr_lo;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_axi_bridge.sv
// AHB slave that issues each accepted AHB beat as a single-beat AXI transaction,
// holding the AHB data phase in wait states until the AXI response returns.
module ahb_axi_bridge
    import ahb_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic        a_clk,
    input  logic        a_resetn,
    input  logic        h_sel,
    input  logic [31:0] h_addr,
    input  logic [1:0]  h_trans,
    input  logic        h_write,
    input  logic [2:0]  h_size,
    input  logic [2:0]  h_burst,
    input  logic [31:0] h_wdata,
    input  logic [3:0]  h_wstrb,
    input  logic        h_ready_in,
    output logic        h_ready_out,
    output logic        h_resp,
    output logic [31:0] h_rdata,
    output logic [3:0]  aw_id,
    output logic [31:0] aw_addr,
    output logic [3:0]  aw_len,
    output logic [2:0]  aw_size,
    output logic [1:0]  aw_burst,
    output logic        aw_valid,
    input  logic        aw_ready,
    output logic [3:0]  w_id,
    output logic [31:0] w_data,
    output logic [3:0]  w_strb,
    output logic        w_last,
    output logic        w_valid,
    input  logic        w_ready,
    input  logic [3:0]  b_id,
    input  logic [1:0]  b_resp,
    input  logic        b_valid,
    output logic        b_ready,
    output logic [3:0]  ar_id,
    output logic [31:0] ar_addr,
    output logic [3:0]  ar_len,
    output logic [2:0]  ar_size,
    output logic [1:0]  ar_burst,
    output logic        ar_valid,
    input  logic        ar_ready,
    input  logic [3:0]  r_id,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    input  logic        r_last,
    input  logic        r_valid,
    output logic        r_ready
);

    bridge_state_e state_q, state_d;
    logic [31:0]   addr_q;
    logic [2:0]    size_q;
    logic          aw_pend_q, w_pend_q;
    logic          illegal, accept;
    logic          aw_done, w_done;
    logic          unused_inputs;

    ahb_xfer_check u_xfer_check (
        .h_size    (h_size),
        .h_addr_lo (h_addr[1:0]),
        .illegal   (illegal)
    );

    assign accept  = h_sel & h_trans[1] & h_ready_in & h_ready_out;
    assign aw_done = ~aw_pend_q | aw_ready;
    assign w_done  = ~w_pend_q | w_ready;

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (accept) begin
                    if (illegal)      state_d = ST_ERR1;
                    else if (h_write) state_d = ST_WA;
                    else              state_d = ST_RA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WA:   if (aw_done && w_done) state_d = ST_WB;
            ST_WB:   if (b_valid) state_d = b_resp[1] ? ST_ERR1 : ST_IDLE;
            ST_RA:   if (ar_ready) state_d = ST_RD;
            ST_RD:   if (r_valid) state_d = r_resp[1] ? ST_ERR1 : ST_IDLE;
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        h_ready_out = 1'b0;
        h_resp      = 1'b0;
        b_ready     = 1'b0;
        ar_valid    = 1'b0;
        r_ready     = 1'b0;
        case (state_q)
            ST_IDLE: h_ready_out = 1'b1;
            ST_WB:   b_ready     = 1'b1;
            ST_RA:   ar_valid    = 1'b1;
            ST_RD:   r_ready     = 1'b1;
            ST_ERR1: h_resp      = 1'b1;
            ST_ERR2: begin
                h_ready_out = 1'b1;
                h_resp      = 1'b1;
            end
            default: h_ready_out = 1'b0;
        endcase
    end

    // Write address and data channels retire independently; WA exits once both are done.
    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
        end else if (accept && !illegal && h_write) begin
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
        end else begin
            if (aw_ready) aw_pend_q <= 1'b0;
            if (w_ready)  w_pend_q  <= 1'b0;
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn) begin
            addr_q <= '0;
            size_q <= '0;
        end else if (accept) begin
            addr_q <= h_addr;
            size_q <= h_size;
        end
    end

    always_ff @(posedge a_clk or negedge a_resetn) begin
        if (!a_resetn)                      h_rdata <= '0;
        else if (state_q == ST_RD && r_valid) h_rdata <= r_data;
    end

    assign aw_id    = AXI_ID;
    assign aw_addr  = addr_q;
    assign aw_len   = AXI_LEN_SINGLE;
    assign aw_size  = size_q;
    assign aw_burst = AXI_BURST_INCR;
    assign aw_valid = aw_pend_q;

    assign w_id     = AXI_ID;
    assign w_data   = h_wdata;
    assign w_strb   = h_wstrb;
    assign w_last   = 1'b1;
    assign w_valid  = w_pend_q;

    assign ar_id    = AXI_ID;
    assign ar_addr  = addr_q;
    assign ar_len   = AXI_LEN_SINGLE;
    assign ar_size  = size_q;
    assign ar_burst = AXI_BURST_INCR;

    assign unused_inputs = ^{h_trans[0], h_burst, b_id, b_resp[0], r_id, r_resp[0], r_last};

endmodule
